// File: rtl/ysyx_24080014_pkg.sv
// Shared definitions for the ysyx_24080014 NPC.
//   - ifu_state_e : instruction-fetch FSM states (2-bit)
//   - AXI_RESP_OKAY : AXI read response value meaning success
//   - DEFAULT_RESET_PC : address of the first fetch after reset
package ysyx_24080014_pkg;

    typedef enum logic [1:0] {
        IFU_IDLE = 2'd0,
        IFU_AR   = 2'd1,
        IFU_R    = 2'd2,
        IFU_OUT  = 2'd3
    } ifu_state_e;

    localparam logic [1:0]  AXI_RESP_OKAY    = 2'b00;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ysyx_24080014_ifu_fetch.sv
// Instruction-fetch initiator: holds the fetch PC and performs one AXI4-Lite
// read at a time from the instruction SRAM. It hands the word, its PC and a
// fault flag to the IDU. A new fetch starts only after the IDU has consumed
// the previous instruction and the next PC has been delivered.
// Ports:
//   aclk, areset        clock, synchronous active-high reset
//   pc_in/valid/ready   next fetch address from WBU
//   ar*/r*              AXI4-Lite read-address and read-data channels
//   inst*               instruction, PC and fault flag toward the IDU
//   fetch_cnt           completed instruction handshakes (wraps)
module ysyx_24080014_ifu_fetch
    import ysyx_24080014_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [31:0] pc_in,
    input  logic        pc_valid,
    output logic        pc_ready,
    output logic        arvalid,
    input  logic        arready,
    output logic [31:0] araddr,
    input  logic        rvalid,
    output logic        rready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_fault,
    output logic [31:0] fetch_cnt
);

    ifu_state_e  state_q, state_d;
    logic        pc_ready_q, arvalid_q, rready_q, inst_valid_q;
    logic [31:0] araddr_q, inst_q, inst_pc_q, fetch_cnt_q;
    logic        inst_fault_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IFU_IDLE: begin
                if (pc_valid) begin
                    if (pc_in[1:0] == 2'b00) state_d = IFU_AR;
                    else                     state_d = IFU_OUT;
                end
            end
            IFU_AR:  if (arready)    state_d = IFU_R;
            IFU_R:   if (rvalid)     state_d = IFU_OUT;
            IFU_OUT: if (inst_ready) state_d = IFU_IDLE;
            default: state_d = IFU_AR;
        endcase
    end

    // Handshake flags are registered one-hot copies of the next state, so
    // they never depend combinationally on a handshake input.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= IFU_AR;
            pc_ready_q   <= 1'b0;
            arvalid_q    <= 1'b1;
            rready_q     <= 1'b0;
            inst_valid_q <= 1'b0;
            araddr_q     <= RESET_PC;
            inst_pc_q    <= RESET_PC;
            inst_q       <= '0;
            inst_fault_q <= 1'b0;
            fetch_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            pc_ready_q   <= (state_d == IFU_IDLE);
            arvalid_q    <= (state_d == IFU_AR);
            rready_q     <= (state_d == IFU_R);
            inst_valid_q <= (state_d == IFU_OUT);
            unique case (state_q)
                IFU_IDLE: begin
                    if (pc_valid) begin
                        araddr_q <= pc_in;
                        // Misaligned PC: skip the bus and report a fault.
                        if (pc_in[1:0] != 2'b00) begin
                            inst_q       <= '0;
                            inst_fault_q <= 1'b1;
                            inst_pc_q    <= pc_in;
                        end
                    end
                end
                IFU_R: begin
                    if (rvalid) begin
                        inst_q       <= rdata;
                        inst_pc_q    <= araddr_q;
                        inst_fault_q <= (rresp != AXI_RESP_OKAY);
                    end
                end
                IFU_OUT: begin
                    if (inst_ready) fetch_cnt_q <= fetch_cnt_q + 32'd1;
                end
                default: ;
            endcase
        end
    end

    // The state register already sits in AR during reset so the first fetch
    // issues on the first cycle after release; the request is held off while
    // reset is still asserted.
    assign arvalid    = arvalid_q & ~areset;
    assign pc_ready   = pc_ready_q;
    assign rready     = rready_q;
    assign inst_valid = inst_valid_q;
    assign araddr     = araddr_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_fault = inst_fault_q;
    assign fetch_cnt  = fetch_cnt_q;

endmodule

// File: tb/tb_ysyx_24080014_ifu_fetch.sv
// Directed bench for ysyx_24080014_ifu_fetch with a behavioural AXI slave and
// an IDU-side scoreboard that checks every consumed instruction.
module tb_ysyx_24080014_ifu_fetch;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [31:0] pc_in = '0;
    logic        pc_valid = 1'b0;
    logic        pc_ready;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] araddr;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = 2'b00;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;
    logic [31:0] fetch_cnt;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
        logic        fault;
    } exp_t;
    exp_t sb_q[$];

    // slave configuration
    int unsigned ar_wait = 0;
    int unsigned r_wait  = 0;
    logic        cfg_err = 1'b0;

    always #5 aclk = ~aclk;

    ysyx_24080014_ifu_fetch #(.RESET_PC(32'h8000_0000)) dut (
        .aclk       (aclk),
        .areset     (areset),
        .pc_in      (pc_in),
        .pc_valid   (pc_valid),
        .pc_ready   (pc_ready),
        .arvalid    (arvalid),
        .arready    (arready),
        .araddr     (araddr),
        .rvalid     (rvalid),
        .rready     (rready),
        .rdata      (rdata),
        .rresp      (rresp),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_fault (inst_fault),
        .fetch_cnt  (fetch_cnt)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Behavioural AXI4-Lite slave; acts just after each falling edge.
    int unsigned ar_cnt = 0;
    int unsigned r_cnt  = 0;
    int unsigned phase  = 0;
    logic [31:0] s_addr = '0;
    always @(negedge aclk) begin
        #1;
        if (areset) begin
            arready = 1'b0; rvalid = 1'b0; phase = 0; ar_cnt = 0; r_cnt = 0;
        end else begin
            case (phase)
                0: begin
                    if (arvalid) begin
                        if (ar_cnt == ar_wait) begin
                            arready = 1'b1; s_addr = araddr; phase = 1; r_cnt = 0;
                        end else begin
                            ar_cnt++;
                        end
                    end else begin
                        arready = 1'b0; ar_cnt = 0;
                    end
                end
                1: begin
                    arready = 1'b0;
                    if (r_cnt == r_wait) begin
                        rvalid = 1'b1;
                        rdata  = cfg_err ? 32'hDEAD_BEEF : mem_word(s_addr);
                        rresp  = cfg_err ? 2'b10 : 2'b00;
                        phase  = 2;
                    end else begin
                        r_cnt++;
                    end
                end
                default: begin
                    rvalid = 1'b0; phase = 0; ar_cnt = 0;
                end
            endcase
        end
    end

    // IDU-side scoreboard: compares every instruction handshake.
    logic [31:0] exp_cnt = '0;
    always @(posedge aclk) begin
        if (areset) begin
            exp_cnt = '0;
        end else if (inst_valid && inst_ready) begin
            checks++;
            assert (sb_q.size() != 0) else begin
                errors++;
                $error("FAIL sb_unexpected: observed inst_pc=%h expected=no instruction", inst_pc);
            end
            if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_inst",  inst, e.word);
                chk("sb_pc",    inst_pc, e.pc);
                chk("sb_fault", 32'(inst_fault), 32'(e.fault));
            end
            chk("sb_fetch_cnt", fetch_cnt, exp_cnt);
            exp_cnt = exp_cnt + 32'd1;
        end
    end

    task automatic send_pc(input logic [31:0] a, input logic push, input exp_t e);
        for (int i = 0; i < 50 && !pc_ready; i++) @(negedge aclk);
        chk("pc_ready_wait", 32'(pc_ready), 32'd1);
        pc_in = a;
        pc_valid = 1'b1;
        if (push) sb_q.push_back(e);
        @(negedge aclk);
        pc_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge aclk);
        chk("drain", 32'(sb_q.size()), 32'd0);
        @(negedge aclk);
    endtask

    initial begin
        // 1: reset and automatic first fetch
        @(negedge aclk);
        @(negedge aclk);
        chk("rst_arvalid", 32'(arvalid), 32'd0);
        chk("rst_araddr", araddr, 32'h8000_0000);
        chk("rst_inst_pc", inst_pc, 32'h8000_0000);
        chk("rst_inst", inst, 32'd0);
        chk("rst_fault", 32'(inst_fault), 32'd0);
        chk("rst_cnt", fetch_cnt, 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        sb_q.push_back('{word: mem_word(32'h8000_0000), pc: 32'h8000_0000, fault: 1'b0});
        areset = 1'b0;
        #1;
        chk("c0_arvalid", 32'(arvalid), 32'd1);
        chk("c0_araddr", araddr, 32'h8000_0000);
        @(negedge aclk);
        chk("c1_rready", 32'(rready), 32'd1);
        @(negedge aclk);
        chk("c2_inst_valid", 32'(inst_valid), 32'd1);
        @(negedge aclk);
        chk("c3_cnt", fetch_cnt, 32'd1);
        chk("c3_pc_ready", 32'(pc_ready), 32'd1);

        // 2: slave wait states
        ar_wait = 5; r_wait = 3;
        send_pc(32'h8000_0010, 1'b1, '{word: mem_word(32'h8000_0010), pc: 32'h8000_0010, fault: 1'b0});
        for (int i = 0; i < 6; i++) begin
            chk("ws_arvalid", 32'(arvalid), 32'd1);
            chk("ws_araddr", araddr, 32'h8000_0010);
            chk("ws_no_inst", 32'(inst_valid), 32'd0);
            @(negedge aclk);
        end
        for (int i = 0; i < 4; i++) begin
            chk("ws_rready", 32'(rready), 32'd1);
            chk("ws_no_inst_r", 32'(inst_valid), 32'd0);
            @(negedge aclk);
        end
        chk("ws_inst_valid", 32'(inst_valid), 32'd1);
        wait_drain();
        ar_wait = 0; r_wait = 0;

        // 3: misaligned PC
        send_pc(32'h8000_0002, 1'b1, '{word: 32'd0, pc: 32'h8000_0002, fault: 1'b1});
        chk("mis_arvalid", 32'(arvalid), 32'd0);
        chk("mis_inst_valid", 32'(inst_valid), 32'd1);
        wait_drain();

        // 4: bus error, then a normal fetch
        cfg_err = 1'b1;
        send_pc(32'h8000_0008, 1'b1, '{word: 32'hDEAD_BEEF, pc: 32'h8000_0008, fault: 1'b1});
        wait_drain();
        cfg_err = 1'b0;
        send_pc(32'h8000_0004, 1'b1, '{word: mem_word(32'h8000_0004), pc: 32'h8000_0004, fault: 1'b0});
        wait_drain();

        // 5: IDU back-pressure with stray pc_valid pulses
        inst_ready = 1'b0;
        send_pc(32'h8000_000C, 1'b1, '{word: mem_word(32'h8000_000C), pc: 32'h8000_000C, fault: 1'b0});
        for (int i = 0; i < 20 && !inst_valid; i++) @(negedge aclk);
        for (int i = 0; i < 10; i++) begin
            pc_in = 32'h8000_0100;
            pc_valid = (i % 2 == 0);
            chk("bp_valid", 32'(inst_valid), 32'd1);
            chk("bp_inst", inst, mem_word(32'h8000_000C));
            chk("bp_pc", inst_pc, 32'h8000_000C);
            chk("bp_fault", 32'(inst_fault), 32'd0);
            chk("bp_pc_ready", 32'(pc_ready), 32'd0);
            @(negedge aclk);
        end
        pc_valid = 1'b0;
        inst_ready = 1'b1;
        wait_drain();
        send_pc(32'h8000_0014, 1'b1, '{word: mem_word(32'h8000_0014), pc: 32'h8000_0014, fault: 1'b0});
        wait_drain();

        // 6: reset while waiting in R
        r_wait = 8;
        send_pc(32'h8000_0020, 1'b0, '0);
        for (int i = 0; i < 20 && !rready; i++) @(negedge aclk);
        chk("mr_in_r", 32'(rready), 32'd1);
        areset = 1'b1;
        @(negedge aclk);
        chk("mr_arvalid", 32'(arvalid), 32'd0);
        chk("mr_araddr", araddr, 32'h8000_0000);
        chk("mr_cnt", fetch_cnt, 32'd0);
        chk("mr_rready", 32'(rready), 32'd0);
        chk("mr_inst_valid", 32'(inst_valid), 32'd0);
        r_wait = 0;
        @(negedge aclk);
        sb_q.push_back('{word: mem_word(32'h8000_0000), pc: 32'h8000_0000, fault: 1'b0});
        areset = 1'b0;
        wait_drain();
        chk("mr_cnt_after", fetch_cnt, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
